// File: rtl/stream_writer.sv
// stream_writer: copies NUM_WORDS words from a show-ahead input channel into a
// single-port memory, starting at a byte address BASE, and keeps a running
// 32-bit checksum plus a word count.
//
// Build option: define STREAM_WRITER_READBACK_EN to add READ/DRAIN phases that
// read the block back and checksum the read data. Without it the checksum is
// summed from the channel words as they are written and MEM_RE stays 0.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   START, BASE       one-cycle start request (IDLE only), start byte address
//   IN_Q, IN_EMPTY    channel head word and empty flag
//   IN_RE             channel pop (combinational, FILL only)
//   MEM_ADDR, MEM_D   memory byte address and write data
//   MEM_WE, MEM_RE    memory write / read strobes (combinational)
//   MEM_Q             memory read data, one cycle after MEM_RE
//   BUSY, DONE        transfer active, one-cycle completion pulse
//   COUNT, CHECKSUM   words written, modulo-2^32 checksum
module stream_writer #(
    parameter int unsigned W_A        = 20,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 256,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [W_A-1:0]        BASE,
    input  logic [DATA_WIDTH-1:0] IN_Q,
    input  logic                  IN_EMPTY,
    output logic                  IN_RE,
    output logic [W_A-1:0]        MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_D,
    output logic                  MEM_WE,
    output logic                  MEM_RE,
    input  logic [DATA_WIDTH-1:0] MEM_Q,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [15:0]           COUNT,
    output logic [31:0]           CHECKSUM
);

    localparam int unsigned  CW       = 16;
    localparam int unsigned  SW       = 32;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
    localparam logic [W_A-1:0] STEP    = W_A'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [W_A-1:0]  addr_q, addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wr_c;
    logic            rd_c;

`ifdef STREAM_WRITER_READBACK_EN
    logic [W_A-1:0]  base_q, base_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            rd_dly_q, rd_dly_d;
`else
    logic            unused_mem_q;
    assign unused_mem_q = ^MEM_Q;
`endif

    // Next-state, datapath updates and strobe requests
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        sum_d   = sum_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wr_c    = 1'b0;
        rd_c    = 1'b0;
`ifdef STREAM_WRITER_READBACK_EN
        base_d   = base_q;
        rd_cnt_d = rd_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_FILL;
                    addr_d  = BASE;
                    count_d = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
`ifdef STREAM_WRITER_READBACK_EN
                    base_d  = BASE;
`endif
                end
            end

            S_FILL: begin
                // An empty channel simply holds everything for this cycle
                if (!IN_EMPTY) begin
                    wr_c    = 1'b1;
                    addr_d  = addr_q + STEP;
                    count_d = count_q + CW'(1);
`ifndef STREAM_WRITER_READBACK_EN
                    sum_d   = sum_q + SW'(IN_Q);
`endif
                    if (count_q == LAST_IDX) begin
`ifdef STREAM_WRITER_READBACK_EN
                        state_d  = S_READ;
                        addr_d   = base_q;
                        rd_cnt_d = '0;
`else
                        state_d  = S_FIN;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
`endif
                    end
                end
            end

`ifdef STREAM_WRITER_READBACK_EN
            S_READ: begin
                rd_c     = 1'b1;
                addr_d   = addr_q + STEP;
                rd_cnt_d = rd_cnt_q + CW'(1);
                if (rd_cnt_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end
            end

            // Last read data arrives here and is accumulated below
            S_DRAIN: begin
                state_d = S_FIN;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`endif

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef STREAM_WRITER_READBACK_EN
        // Read data is valid the cycle after the read strobe
        rd_dly_d = rd_c;
        if (rd_dly_q) begin
            sum_d = sum_q + SW'(MEM_Q);
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef STREAM_WRITER_READBACK_EN
            base_q   <= '0;
            rd_cnt_q <= '0;
            rd_dly_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef STREAM_WRITER_READBACK_EN
            base_q   <= base_d;
            rd_cnt_q <= rd_cnt_d;
            rd_dly_q <= rd_dly_d;
`endif
        end
    end

    // Strobes are suppressed while reset is asserted so nothing is written or popped
    assign IN_RE    = wr_c & ~RST;
    assign MEM_WE   = wr_c & ~RST;
    assign MEM_RE   = rd_c & ~RST;
    assign MEM_ADDR = addr_q;
    assign MEM_D    = (state_q == S_FILL) ? IN_Q : '0;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign COUNT    = count_q;
    assign CHECKSUM = sum_q;

endmodule

// File: tb/tb_stream_writer.sv
// Self-checking bench for stream_writer (W_A=12, NUM_WORDS=4, ADDR_STEP=4).
// A transfer-level model (words written so far, cycles since the fill ended)
// predicts every output each cycle; literal checks pin the directed cases.
`timescale 1ns/1ps
module tb_stream_writer;

    localparam int unsigned W_A  = 12;
    localparam int unsigned DW   = 32;
    localparam int          N    = 4;
    localparam int          STEP = 4;
`ifdef STREAM_WRITER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           START = 1'b0;
    logic [W_A-1:0] BASE = '0;
    logic [DW-1:0]  IN_Q = '0;
    logic           IN_EMPTY = 1'b1;
    logic           IN_RE;
    logic [W_A-1:0] MEM_ADDR;
    logic [DW-1:0]  MEM_D;
    logic           MEM_WE;
    logic           MEM_RE;
    logic [DW-1:0]  MEM_Q = '0;
    logic           BUSY;
    logic           DONE;
    logic [15:0]    COUNT;
    logic [31:0]    CHECKSUM;

    stream_writer #(
        .W_A        (W_A),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (N),
        .ADDR_STEP  (STEP)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .BASE     (BASE),
        .IN_Q     (IN_Q),
        .IN_EMPTY (IN_EMPTY),
        .IN_RE    (IN_RE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_D    (MEM_D),
        .MEM_WE   (MEM_WE),
        .MEM_RE   (MEM_RE),
        .MEM_Q    (MEM_Q),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .COUNT    (COUNT),
        .CHECKSUM (CHECKSUM)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Channel, memory and observation logs
    logic [31:0]    words [N];
    int             ptr = N;
    int             gap_left = 0;
    int             empty_pct = 0;
    logic [31:0]    mem [1 << W_A];
    bit             rd_pend = 1'b0;
    logic [W_A-1:0] rd_addr = '0;
    int             cyc = 0;
    int             done_cnt = 0;
    int             re_cnt = 0;
    logic [W_A-1:0] wr_addr_log [$];
    int             wr_cyc_log [$];

    // Behavioural model
    bit             m_valid = 1'b0;
    bit             m_active = 1'b0;
    int             m_wr = 0;
    int             m_post = 0;
    logic [W_A-1:0] m_base = '0;
    logic [W_A-1:0] m_last = '0;
    logic [31:0]    m_sum = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W_A-1:0] addr_of(input logic [W_A-1:0] b, input int k);
        return W_A'(int'(b) + k * STEP);
    endfunction

    // Channel and memory-read drivers, just after each rising edge
    always @(posedge CLK) begin
        #1;
        if (ptr >= N) begin
            IN_EMPTY = 1'b1;
        end else if (ptr == 2 && gap_left > 0) begin
            IN_EMPTY = 1'b1;
            gap_left--;
        end else begin
            IN_EMPTY = ($urandom_range(99) < 32'(empty_pct)) ? 1'b1 : 1'b0;
        end
        IN_Q  = (ptr < N) ? words[ptr] : $urandom;
        MEM_Q = rd_pend ? mem[rd_addr] : $urandom;
    end

    // Compare process: check outputs against the model, then advance everything
    always @(negedge CLK) begin
        bit fill, rd, fin;
        fill = m_active && (m_wr < N);
        rd   = RB && m_active && (m_wr == N) && (m_post < N);
        fin  = m_active && (m_wr == N) && (m_post == (RB ? N + 1 : 0));
        cyc++;

        if (m_valid) begin
            chk("mem_we",   32'(MEM_WE), 32'(fill && !IN_EMPTY && !RST));
            chk("in_re",    32'(IN_RE),  32'(fill && !IN_EMPTY && !RST));
            chk("mem_re",   32'(MEM_RE), 32'(rd && !RST));
            chk("busy",     32'(BUSY),   32'(m_active && !fin));
            chk("done",     32'(DONE),   32'(fin));
            chk("count",    32'(COUNT),  32'(m_wr));
            chk("checksum", CHECKSUM,    m_sum);
            if (fill) chk("fill_addr", 32'(MEM_ADDR), 32'(addr_of(m_base, m_wr)));
            if (fill && !IN_EMPTY) chk("fill_data", MEM_D, words[m_wr]);
            if (rd) chk("read_addr", 32'(MEM_ADDR), 32'(addr_of(m_base, m_post)));
            if (!m_active) begin
                chk("idle_addr", 32'(MEM_ADDR), 32'(m_last));
                chk("idle_data", MEM_D, 32'h0);
            end
        end

        if (MEM_WE === 1'b1) begin
            mem[MEM_ADDR] = MEM_D;
            wr_addr_log.push_back(MEM_ADDR);
            wr_cyc_log.push_back(cyc);
        end
        rd_pend = (MEM_RE === 1'b1);
        rd_addr = MEM_ADDR;
        if (MEM_RE === 1'b1) re_cnt++;
        if (IN_RE === 1'b1) ptr++;
        if (DONE === 1'b1) done_cnt++;

        if (RST) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_wr     = 0;
            m_post   = 0;
            m_sum    = '0;
            m_last   = '0;
        end else if (!m_active) begin
            if (START) begin
                m_active = 1'b1;
                m_base   = BASE;
                m_wr     = 0;
                m_post   = 0;
                m_sum    = '0;
            end
        end else if (fill) begin
            if (!IN_EMPTY) begin
                if (!RB) m_sum = m_sum + words[m_wr];
                m_wr++;
            end
        end else if (fin) begin
            m_active = 1'b0;
            m_last   = addr_of(m_base, N);
        end else begin
            if (RB && m_post >= 1 && m_post <= N) m_sum = m_sum + words[m_post - 1];
            m_post++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One transfer; optionally pulses START again while it is in progress
    task automatic xfer(input logic [W_A-1:0] b, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3,
                        input int epct, input int gap, input bit mid_start);
        int budget;
        int d0;
        @(negedge CLK);
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        ptr = 0; gap_left = gap; empty_pct = epct;
        wr_addr_log.delete(); wr_cyc_log.delete(); re_cnt = 0;
        d0 = done_cnt;
        @(posedge CLK); #1;
        BASE = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        BASE  = W_A'($urandom);
        budget = 0;
        while (done_cnt == d0 && budget < 300) begin
            @(posedge CLK); #1;
            budget++;
            START = (mid_start && budget == (RB ? 5 : 2)) ? 1'b1 : 1'b0;
        end
        START = 1'b0;
        if (done_cnt == d0) chk("done_timeout", 32'(done_cnt - d0), 32'd1);
        tick(3);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("read_strobes", 32'(re_cnt), RB ? 32'(N) : 32'd0);
    endtask

    initial begin
        logic [W_A-1:0] exp_a [N];
        int d0;

        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        tick(2);
        chk("rst_busy",  32'(BUSY),     32'd0);
        chk("rst_count", 32'(COUNT),    32'd0);
        chk("rst_sum",   CHECKSUM,      32'd0);
        chk("rst_addr",  32'(MEM_ADDR), 32'd0);

        // Four back-to-back writes at 0x100
        xfer(12'h100, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 1'b0);
        exp_a[0] = 12'h100; exp_a[1] = 12'h104; exp_a[2] = 12'h108; exp_a[3] = 12'h10C;
        chk("t1_nwrites", 32'(wr_addr_log.size()), 32'd4);
        for (int i = 0; i < N && i < wr_addr_log.size(); i++) begin
            chk("t1_addr", 32'(wr_addr_log[i]), 32'(exp_a[i]));
            if (i > 0) chk("t1_consec", 32'(wr_cyc_log[i] - wr_cyc_log[i - 1]), 32'd1);
        end
        chk("t1_count", 32'(COUNT), 32'd4);
        chk("t1_sum",   CHECKSUM,   32'd10);
        chk("t1_busy",  32'(BUSY),  32'd0);

        // Three-cycle channel gap after the second word
        xfer(12'h100, 32'd1, 32'd2, 32'd3, 32'd4, 0, 3, 1'b0);
        chk("t2_nwrites", 32'(wr_addr_log.size()), 32'd4);
        for (int i = 0; i < N && i < wr_addr_log.size(); i++)
            chk("t2_addr", 32'(wr_addr_log[i]), 32'(exp_a[i]));
        if (wr_cyc_log.size() == N) chk("t2_gap", 32'(wr_cyc_log[2] - wr_cyc_log[1]), 32'd4);
        chk("t2_sum", CHECKSUM, 32'd10);

        // Address wrap through the top of the 12-bit space
        xfer(12'hFF8, $urandom, $urandom, $urandom, $urandom, 0, 0, 1'b0);
        exp_a[0] = 12'hFF8; exp_a[1] = 12'hFFC; exp_a[2] = 12'h000; exp_a[3] = 12'h004;
        chk("t3_nwrites", 32'(wr_addr_log.size()), 32'd4);
        for (int i = 0; i < N && i < wr_addr_log.size(); i++)
            chk("t3_addr", 32'(wr_addr_log[i]), 32'(exp_a[i]));
        chk("t3_idle_addr", 32'(MEM_ADDR), 32'h008);

        // Checksum wraps modulo 2^32
        xfer(12'h040, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0, 0, 0, 1'b0);
        chk("t4_sum", CHECKSUM, 32'h0000_0001);

        // Reset during the second write aborts without DONE
        @(negedge CLK);
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        ptr = 0; gap_left = 0; empty_pct = 0;
        wr_addr_log.delete(); wr_cyc_log.delete();
        d0 = done_cnt;
        @(posedge CLK); #1;
        BASE = 12'h200; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        tick(6);
        chk("t5_nwrites", 32'(wr_addr_log.size()), 32'd1);
        chk("t5_done",    32'(done_cnt - d0),      32'd0);
        chk("t5_busy",    32'(BUSY),               32'd0);
        chk("t5_count",   32'(COUNT),              32'd0);
        chk("t5_sum",     CHECKSUM,                32'd0);

        xfer(12'h000, 32'd5, 32'd6, 32'd7, 32'd8, 0, 0, 1'b0);
        chk("t6_count", 32'(COUNT), 32'd4);
        chk("t6_sum",   CHECKSUM,   32'd26);

        // START while busy is ignored
        xfer(12'h300, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 1'b1);
        chk("t7_sum",   CHECKSUM,   32'd10);
        chk("t7_count", 32'(COUNT), 32'd4);

        // Randomized transfers with channel stalls and stray STARTs
        for (int t = 0; t < 25; t++) begin
            xfer(W_A'($urandom), $urandom, $urandom, $urandom, $urandom,
                 int'($urandom_range(50)), 0, 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
